alu_1bit: RTL and testbench
===========================

# alu_1bit

Single-bit logic unit that applies one of four bitwise operations to inputs `a` and `b`, chosen by a 2-bit opcode. It is the per-bit slice for wider ALUs and is also used standalone as a selectable gate. The result is registered by default. A parameter makes it purely combinational for ripple-style composition.

## Interface

Parameters:
- `REG_OUT`, default 1. When 1, `y` is registered on `clk`. When 0, `y` is combinational; `clk` and `rst_n` have no effect.

Ports:
- `clk`  input  1  system clock; the rising edge is active.
- `rst_n`  input  1  reset; one clock, and reset is asynchronous and active-low.
- `a`  input  1  operand A.
- `b`  input  1  operand B.
- `sel`  input  2  operation select.
- `y`  output  1  result.

## Operation

- Opcode map:
  - `sel`=00 gives AND: `y` = a & b.
  - `sel`=01 gives OR: `y` = a | b.
  - `sel`=10 gives XOR: `y` = a ^ b.
  - `sel`=11 gives NOT: `y` = ~a. `b` is ignored.
- All four `sel` codes are defined. There is no illegal-opcode state.
- X or Z on `sel` must not be masked. The simulated `y` may go X. Synthesis treats the decode as full-case.
- There is no state other than the output register when `REG_OUT`=1.
- Truth table the bench compares against, with rows in order ab = 00, 10, 01, 11:
  - AND gives 0, 0, 0, 1.
  - OR gives 0, 1, 1, 1.
  - XOR gives 0, 1, 1, 0.
  - NOT gives 1, 0, 1, 0.

## Timing

- `REG_OUT`=1:
  - Latency is one cycle. `y` at rising edge N+1 reflects `a`, `b` and `sel` sampled at edge N.
  - A new operation is accepted every cycle. There is no handshake.
  - `rst_n` low forces `y`=0 immediately, with no clock edge needed, and holds it at 0 while low.
  - The first update after release comes at the first rising edge with `rst_n` high. That edge samples the current inputs.
  - If reset asserts during operation, the pending result is discarded and `y`=0.
  - If `sel` changes on the same edge as `a`/`b`, all three are sampled together. No mixed-opcode result is possible.
- `REG_OUT`=0:
  - `y` follows the inputs combinationally with zero cycles of latency.
  - `rst_n` is ignored. There is no reset value.
- Inputs must meet setup and hold to `clk` when `REG_OUT`=1. There is no internal synchronizer.

## Structure

- Package `alu_1bit_pkg`:
  - enum `alu_op_e` (2 bits) with `OP_AND`=2'b00, `OP_OR`=2'b01, `OP_XOR`=2'b10, `OP_NOT`=2'b11.
  - a reset constant `Y_RST`=1'b0.
- Sub-module `alu_1bit_core`:
  - purely combinational: `a`, `b`, `sel` in, `y_comb` out.
  - contains only the opcode decode.
- Top `alu_1bit`:
  - instantiates the core.
  - generate-selects the async-reset output flop or a direct pass-through on `REG_OUT`.
- Wider ALUs instantiate `alu_1bit_core` per bit, not the registered top.

## Test plan

- Exhaustive sweep with `REG_OUT`=1: all 16 combinations of {sel, a, b}, one per cycle. Each `y` one cycle later matches the truth table, e.g. sel=11, a=0, b=1 gives y=1.
- Reset:
  - Drive sel=11, a=0 and clock until y=1.
  - Assert `rst_n`=0 mid-cycle. `y`=0 immediately, before the next edge.
  - Hold for 3 edges. `y` stays 0.
  - Release `rst_n`. After the first edge, y=1.
- Back-to-back opcode change:
  - cycle N: sel=00, a=1, b=1.
  - cycle N+1: sel=10, a=1, b=1.
  - `y` shows 1, then 0, on consecutive cycles.
- Operand ignore: sel=11, a=1, and toggle `b` every cycle. `y` stays 0 throughout.
- Combinational variant with `REG_OUT`=0 and `clk` held at 0:
  - apply the same 16-vector sweep at 10-time-unit spacing.
  - `y` is valid within each step and matches the table.
  - pulsing `rst_n` low has no effect on `y`.

Source files
------------

// File: rtl/alu_1bit_pkg.sv
// alu_1bit_pkg: opcode encoding and reset value shared by the 1-bit ALU slice.
package alu_1bit_pkg;
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;
  localparam logic Y_RST = 1'b0;
endpackage

// File: rtl/alu_1bit_core.sv
// alu_1bit_core: combinational opcode decode, the per-bit slice for wider ALUs.
module alu_1bit_core
  import alu_1bit_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] sel,
  output logic       y_comb
);
  // Ternary chain rather than case/default so an unknown sel propagates X in simulation.
  always_comb
    y_comb = (sel == OP_AND) ? (a & b) :
             (sel == OP_OR)  ? (a | b) :
             (sel == OP_XOR) ? (a ^ b) : ~a;
endmodule

// File: rtl/alu_1bit.sv
// alu_1bit: 1-bit logic unit with optional async-reset output register.
module alu_1bit
  import alu_1bit_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic [1:0] sel,
  output logic       y
);
  logic y_comb;
  alu_1bit_core u_core (
    .a      (a),
    .b      (b),
    .sel    (sel),
    .y_comb (y_comb)
  );
  if (REG_OUT) begin : g_reg
    logic y_d, y_q;
    assign y_d = y_comb;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) y_q <= Y_RST;
      else        y_q <= y_d;
    assign y = y_q;
  end else begin : g_comb
    assign y = y_comb;
  end
endmodule

// File: tb/tb_alu_1bit.sv
// tb_alu_1bit: checks registered and combinational alu_1bit against an arithmetic model and a literal truth table.
module tb_alu_1bit;
  import alu_1bit_pkg::*;
  logic clk = 0, rst_n = 0, a = 0, b = 0;
  logic [1:0] sel = 2'b00;
  logic y;
  logic cclk = 0, crst_n = 1, ca = 0, cb = 0;
  logic [1:0] csel = 2'b00;
  logic cy;
  int checks = 0, failures = 0;
  bit chk_en = 0;
  logic exp_y;
  // rows in order ab = 00, 10, 01, 11, i.e. index a + 2*b
  bit tbl [4][4] = '{'{0,0,0,1}, '{0,1,1,1}, '{0,1,1,0}, '{1,0,1,0}};

  alu_1bit #(.REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .y(y));
  alu_1bit #(.REG_OUT(1'b0)) u_comb (
    .clk(cclk), .rst_n(crst_n), .a(ca), .b(cb), .sel(csel), .y(cy));

  always #5 clk = ~clk;

  function automatic logic model(logic [1:0] s, logic x, logic z);
    int ia = int'(x), ib = int'(z);
    case (s)
      2'd0:    return (ia * ib) != 0;
      2'd1:    return (ia + ib) > 0;
      2'd2:    return ((ia + ib) % 2) != 0;
      default: return (1 - ia) != 0;
    endcase
  endfunction

  task automatic check(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    exp_y <= !rst_n ? 1'b0 : model(sel, a, b);

  always @(negedge clk)
    if (chk_en) check("model", y, exp_y);

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", y, 1'b0);
    rst_n = 1;
    chk_en = 1;
    // exhaustive sweep, one vector per cycle, literal check one cycle later
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("sweep_%0d", i - 1), y, tbl[sel][int'(a) + 2 * int'(b)]);
      if (i < 16) {sel, a, b} = 4'(i);
    end
    check("not_a0_b1", model(2'b11, 1'b0, 1'b1), 1'b1);
    // reset behaviour
    @(negedge clk);
    sel = 2'b11; a = 0; b = 0;
    for (int k = 0; k < 10 && y !== 1'b1; k++) @(negedge clk);
    check("reach_one", y, 1'b1);
    #2 rst_n = 0;
    #1 check("async_reset", y, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", y, 1'b0);
    end
    rst_n = 1;
    @(posedge clk);
    #1 check("release", y, 1'b1);
    // back-to-back opcode change
    @(negedge clk);
    sel = 2'b00; a = 1; b = 1;
    @(negedge clk);
    check("b2b_and", y, 1'b1);
    sel = 2'b10;
    @(negedge clk);
    check("b2b_xor", y, 1'b0);
    // b ignored under NOT
    sel = 2'b11; a = 1; b = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("not_ignore_b", y, 1'b0);
      b = ~b;
    end
    chk_en = 0;
    // combinational variant
    for (int i = 0; i < 16; i++) begin
      {csel, ca, cb} = 4'(i);
      #5;
      check($sformatf("comb_tbl_%0d", i), cy, tbl[csel][int'(ca) + 2 * int'(cb)]);
      check($sformatf("comb_model_%0d", i), cy, model(csel, ca, cb));
      #5;
    end
    csel = 2'b11; ca = 0; cb = 0;
    #2 check("comb_pre_rst", cy, 1'b1);
    crst_n = 0;
    #3 check("comb_rst_low", cy, 1'b1);
    crst_n = 1;
    #2 check("comb_rst_high", cy, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
